store_commit_buffer: RTL and testbench
======================================

// Module: store_commit_buffer
// PURPOSE
//  - In-order FIFO sitting directly downstream of the store reservation station.
//  - Captures completed stores (tag/address/data) and holds them until the ROB commits each tag.
//  - Drains committed stores to data memory one at a time over a req/ack handshake.
//  - Checks pending stores against load addresses so a load never bypasses an older store.
// PARAMETERS
//  DEPTH   8   number of store entries; power of two, >= 2
//  PTR_W   3   log2(DEPTH); pointer width (count is PTR_W+1 bits)
// PORTS
//  clk          in   1   single clock, rising edge
//  reset        in   1   asynchronous, active-low; clears all state immediately
//  flush        in   1   mispredict flush; discards every uncommitted entry
//  st_ready     in   1   store complete from RS; 1-cycle pulse
//  st_tag       in   6   ROB tag of the store; 0 never valid
//  st_data      in   32  store data
//  st_addr      in   32  effective byte address
//  full         out  1   count==DEPTH (registered); RS must not complete a store while high
//  overflow     out  1   sticky; st_ready seen while full; cleared only by reset
//  commit_valid in   1   ROB commits commit_tag this cycle
//  commit_tag   in   6   tag being committed
//  mem_we       out  1   write request to data memory
//  mem_addr     out  32  write address, stable while mem_we=1
//  mem_wdata    out  32  write data, stable while mem_we=1
//  mem_ack      in   1   memory accepted the write (same cycle as mem_we=1)
//  ld_check     in   1   a load is probing ld_addr
//  ld_addr      in   32  load effective address
//  ld_hit       out  1   forwarding hit (feature macro only)
//  ld_data      out  32  forwarded data (feature macro only)
//  ld_stall     out  1   load must wait: conflicting store still pending
//  count        out  4   valid entries (PTR_W+1 bits)
//  empty        out  1   count==0
// BEHAVIOUR
//  - Reset: all entries invalid; head=tail=count=0; mem_we=0; mem_addr/mem_wdata=0; full=0; overflow=0; empty=1; ld_hit=0; ld_stall=0; ld_data=0.
//  - Entry fields: {valid, committed, tag, addr, data}.
//  - Allocate: st_ready && !full && !flush -> write at tail, committed=0, tail++ (wraps modulo DEPTH).
//  - Reject: st_ready && full -> store dropped, overflow<=1. st_ready && flush -> store dropped, overflow unchanged.
//  - Commit: commit_valid, valid uncommitted entry with tag==commit_tag -> committed<=1 next edge; no match -> ignored.
//  - Commit ordering: stores commit in program order, so committed entries always form a prefix from head.
//  - Drain FSM, IDLE:
//    - head valid && committed -> register mem_addr/mem_wdata from head, mem_we<=1, go WRITE.
//  - Drain FSM, WRITE:
//    - mem_we held, addr/data stable until mem_ack.
//    - On mem_ack: pop head (head++, count--).
//    - If the next entry is valid && committed, load it and stay WRITE (back-to-back, 1 store/cycle max); else mem_we<=0, go IDLE.
//  - Latency: commit edge -> mem_we=1 one cycle later (from IDLE).
//  - Flush: tail <= head + (number of committed entries); uncommitted entries invalidated.
//    - Committed entries and any in-flight WRITE are untouched and complete normally.
//  - Same-cycle events:
//    - commit and flush: commit applied first, so that entry survives.
//    - push and pop: count unchanged.
//    - full uses the registered count, so a pop does not admit a same-cycle push.
//  - Reset mid-WRITE: mem_we drops asynchronously; the store is lost by design.
//  - Load check (combinational): match = any valid entry with addr[31:2]==ld_addr[31:2] while ld_check=1.
//  - Outputs: full, empty and count are registered.
// CONFIGURATION
//  - STORE_FWD_EN defined:
//    - Match on the youngest matching entry with identical full address -> ld_hit=1, ld_data=that entry's data, ld_stall=0.
//    - Word match with a different byte offset -> ld_stall=1, ld_hit=0.
//  - STORE_FWD_EN undefined:
//    - ld_hit=0 and ld_data=0 always.
//    - ld_stall=match; loads wait until the conflicting store drains.
// TESTING
//  - Push tag 5 (addr 0x100, data 0xAA) with no commit -> entry held, mem_we stays 0 for 20 cycles; commit tag 5 -> mem_we=1 next cycle with 0x100/0xAA; ack -> empty=1.
//  - Fill 8 stores, push a 9th -> full=1, overflow=1, count=8; commit all with ack held 1 -> 8 writes on consecutive cycles, in order.
//  - Push tags 1,2,3; commit 1; flush in the same cycle as commit 2 -> entries 1 and 2 drain, 3 is discarded, count ends 0.
//  - Assert reset low mid-WRITE with mem_ack=0 -> mem_we=0 immediately, count=0, overflow=0.
//  - Stores 0x200<-0x11 then 0x200<-0x22, load probe 0x200 -> FWD_EN: ld_hit=1, ld_data=0x22; otherwise ld_stall=1.
//  - Probe 0x202 against store 0x200 -> FWD_EN: ld_stall=1, ld_hit=0; probe 0x300 -> ld_hit=0, ld_stall=0.

Source files
------------

// File: rtl/store_commit_buffer_if.sv
// Bundle of store-in, commit, memory-write and load-probe signals for store_commit_buffer.
// master = environment (RS/ROB/memory/load unit), slave = the buffer itself.
interface store_commit_buffer_if #(
  parameter int PTR_W = 3
);
  logic             flush;
  logic             st_ready;
  logic [5:0]       st_tag;
  logic [31:0]      st_data;
  logic [31:0]      st_addr;
  logic             full;
  logic             overflow;
  logic             commit_valid;
  logic [5:0]       commit_tag;
  // mem_we/mem_ack: a write transfers on any cycle where both are high; mem_addr and
  // mem_wdata hold their value from the rise of mem_we until that cycle.
  logic             mem_we;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_wdata;
  logic             mem_ack;
  logic             ld_check;
  logic [31:0]      ld_addr;
  logic             ld_hit;
  logic [31:0]      ld_data;
  logic             ld_stall;
  logic [PTR_W:0]   count;
  logic             empty;
  logic             dbg_state;

  modport master (
    output flush, st_ready, st_tag, st_data, st_addr, commit_valid, commit_tag,
           mem_ack, ld_check, ld_addr,
    input  full, overflow, mem_we, mem_addr, mem_wdata, ld_hit, ld_data, ld_stall,
           count, empty, dbg_state
  );

  modport slave (
    input  flush, st_ready, st_tag, st_data, st_addr, commit_valid, commit_tag,
           mem_ack, ld_check, ld_addr,
    output full, overflow, mem_we, mem_addr, mem_wdata, ld_hit, ld_data, ld_stall,
           count, empty, dbg_state
  );
endinterface

// File: rtl/store_commit_buffer.sv
// In-order store buffer: holds completed stores until ROB commit, drains them to memory,
// and checks loads against pending stores. Define STORE_FWD_EN to forward exact-address hits.
module store_commit_buffer #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  store_commit_buffer_if.slave  bus
);
  typedef enum logic {S_IDLE, S_WRITE} drain_state_e;

  logic [DEPTH-1:0] valid_q, committed_q, valid_n, committed_n;
  logic [DEPTH-1:0] commit_hit, committed_d;
  logic [5:0]       tag_q  [DEPTH];
  logic [31:0]      addr_q [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [PTR_W-1:0] head_q, tail_q, next_idx, load_idx, age_idx;
  logic [PTR_W:0]   count_q, count_n, n_comm;
  logic             overflow_q, full, push, pop, load_en;
  logic [31:0]      mem_addr_q, mem_wdata_q;
  drain_state_e     state_q, state_d;
  logic             ld_hit_c, ld_stall_c;
  logic [31:0]      ld_data_c;

  assign full     = (count_q == (PTR_W+1)'(DEPTH));
  assign push     = bus.st_ready && !full && !bus.flush;
  assign next_idx = head_q + PTR_W'(1);

  // Commits land before a same-cycle flush, so the committed set below already includes them.
  always_comb begin
    commit_hit = '0;
    n_comm     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      commit_hit[i] = bus.commit_valid && valid_q[i] && !committed_q[i] &&
                      (tag_q[i] == bus.commit_tag);
    end
    committed_d = committed_q | commit_hit;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && committed_d[i]) n_comm = n_comm + (PTR_W+1)'(1);
    end
  end

  always_comb begin
    state_d  = state_q;
    load_en  = 1'b0;
    load_idx = head_q;
    pop      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (valid_q[head_q] && committed_q[head_q]) begin
          load_en = 1'b1;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (bus.mem_ack) begin
          pop = 1'b1;
          if (valid_q[next_idx] && committed_q[next_idx]) begin
            load_en  = 1'b1;
            load_idx = next_idx;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    valid_n     = valid_q;
    committed_n = committed_d;
    if (bus.flush) valid_n = valid_q & committed_d;
    if (pop) valid_n[head_q] = 1'b0;
    if (push) begin
      valid_n[tail_q]     = 1'b1;
      committed_n[tail_q] = 1'b0;
    end
    committed_n = committed_n & valid_n;
    if (bus.flush) count_n = n_comm - (PTR_W+1)'(pop);
    else           count_n = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q     <= '0;
      committed_q <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
    end else begin
      valid_q     <= valid_n;
      committed_q <= committed_n;
      count_q     <= count_n;
      if (bus.st_ready && full) overflow_q <= 1'b1;
      if (pop) head_q <= next_idx;
      // Flush rewinds tail to just past the committed prefix.
      if (bus.flush)  tail_q <= head_q + n_comm[PTR_W-1:0];
      else if (push)  tail_q <= tail_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      tag_q[tail_q]  <= bus.st_tag;
      addr_q[tail_q] <= bus.st_addr;
      data_q[tail_q] <= bus.st_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (load_en) begin
        mem_addr_q  <= addr_q[load_idx];
        mem_wdata_q <= data_q[load_idx];
      end
    end
  end

  // Walk oldest to youngest so the youngest word match decides the result.
  always_comb begin
    ld_hit_c   = 1'b0;
    ld_stall_c = 1'b0;
    ld_data_c  = '0;
    age_idx    = head_q;
    if (bus.ld_check) begin
      for (int i = 0; i < DEPTH; i++) begin
        age_idx = head_q + PTR_W'(i);
        if (valid_q[age_idx] && (addr_q[age_idx][31:2] == bus.ld_addr[31:2])) begin
`ifdef STORE_FWD_EN
          if (addr_q[age_idx][1:0] == bus.ld_addr[1:0]) begin
            ld_hit_c   = 1'b1;
            ld_data_c  = data_q[age_idx];
            ld_stall_c = 1'b0;
          end else begin
            ld_hit_c   = 1'b0;
            ld_data_c  = '0;
            ld_stall_c = 1'b1;
          end
`else
          ld_stall_c = 1'b1;
`endif
        end
      end
    end
  end

  assign bus.full      = full;
  assign bus.empty     = (count_q == '0);
  assign bus.count     = count_q;
  assign bus.overflow  = overflow_q;
  assign bus.mem_we    = (state_q == S_WRITE);
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.ld_hit    = ld_hit_c;
  assign bus.ld_data   = ld_data_c;
  assign bus.ld_stall  = ld_stall_c;
  assign bus.dbg_state = (state_q == S_WRITE);
endmodule

// File: tb/tb_store_commit_buffer.sv
// Bench for store_commit_buffer: directed scenarios plus random traffic against a queue model.
module tb_store_commit_buffer;
  localparam int DEPTH = 8;
  localparam int PTR_W = 3;

  typedef struct {
    logic [5:0]  tag;
    logic [31:0] addr;
    logic [31:0] data;
    bit          committed;
  } st_entry_t;

  logic clk = 1'b0;
  logic reset;

  store_commit_buffer_if #(.PTR_W(PTR_W)) bus();

  store_commit_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  st_entry_t   model_q[$];
  logic [31:0] exp_q[$];
  bit          m_we, m_ovf;
  logic [31:0] m_addr, m_wdata;
  int          err_cnt = 0;
  int          chk_cnt = 0;
  int          writes_seen = 0;
  logic [5:0]  next_tag = 6'd1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    bus.flush = 0; bus.st_ready = 0; bus.st_tag = 0; bus.st_data = 0; bus.st_addr = 0;
    bus.commit_valid = 0; bus.commit_tag = 0; bus.mem_ack = 0;
    bus.ld_check = 0; bus.ld_addr = 0;
  endtask

  task automatic model_ld(output bit hit, output bit stall, output logic [31:0] data);
    hit = 0; stall = 0; data = '0;
    if (bus.ld_check) begin
      for (int i = model_q.size() - 1; i >= 0; i--) begin
        if (model_q[i].addr[31:2] == bus.ld_addr[31:2]) begin
`ifdef STORE_FWD_EN
          if (model_q[i].addr == bus.ld_addr) begin hit = 1; data = model_q[i].data; end
          else stall = 1;
`else
          stall = 1;
`endif
          break;
        end
      end
    end
  endtask

  // One clock: check combinational outputs, advance the model at the edge, check registered outputs.
  task automatic cycle();
    bit e_hit, e_stall, full_now, pop;
    logic [31:0] e_data, exp_w;
    #1;
    model_ld(e_hit, e_stall, e_data);
    check("ld_hit", bus.ld_hit, e_hit);
    check("ld_stall", bus.ld_stall, e_stall);
    check("ld_data", bus.ld_data, e_data);
    if (bus.mem_we && bus.mem_ack) begin
      writes_seen++;
      exp_w = (exp_q.size() > 0) ? exp_q[0] : 32'hDEAD_BEEF;
      if (exp_q.size() > 0) exp_q.pop_front();
      check("wr_order", bus.mem_wdata, exp_w);
    end
    @(posedge clk);
    full_now = (model_q.size() == DEPTH);
    if (bus.st_ready && full_now) m_ovf = 1;
    pop = m_we && bus.mem_ack;
    if (!m_we) begin
      if (model_q.size() > 0 && model_q[0].committed) begin
        m_we = 1; m_addr = model_q[0].addr; m_wdata = model_q[0].data;
      end
    end else if (bus.mem_ack) begin
      if (model_q.size() > 1 && model_q[1].committed) begin
        m_addr = model_q[1].addr; m_wdata = model_q[1].data;
      end else m_we = 0;
    end
    if (bus.commit_valid) begin
      for (int i = 0; i < model_q.size(); i++) begin
        if (!model_q[i].committed && model_q[i].tag == bus.commit_tag) begin
          model_q[i].committed = 1;
          exp_q.push_back(model_q[i].data);
          break;
        end
      end
    end
    if (bus.flush) begin
      for (int i = model_q.size() - 1; i >= 0; i--)
        if (!model_q[i].committed) model_q.delete(i);
    end
    if (pop) model_q.pop_front();
    if (bus.st_ready && !full_now && !bus.flush)
      model_q.push_back('{tag: bus.st_tag, addr: bus.st_addr, data: bus.st_data, committed: 0});
    #1;
    check("mem_we", bus.mem_we, m_we);
    check("dbg_state", bus.dbg_state, m_we);
    check("count", bus.count, 32'(model_q.size()));
    check("full", bus.full, model_q.size() == DEPTH);
    check("empty", bus.empty, model_q.size() == 0);
    check("overflow", bus.overflow, m_ovf);
    if (m_we) begin
      check("mem_addr", bus.mem_addr, m_addr);
      check("mem_wdata", bus.mem_wdata, m_wdata);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 0;
    repeat (2) @(negedge clk);
    model_q.delete(); exp_q.delete();
    m_we = 0; m_ovf = 0; m_addr = 0; m_wdata = 0;
    bus.ld_check = 1; bus.ld_addr = 32'h200;
    #1;
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    check("rst_count", bus.count, 0);
    check("rst_full", bus.full, 0);
    check("rst_empty", bus.empty, 1);
    check("rst_overflow", bus.overflow, 0);
    check("rst_ld_hit", bus.ld_hit, 0);
    check("rst_ld_stall", bus.ld_stall, 0);
    check("rst_ld_data", bus.ld_data, 0);
    idle_inputs();
    reset = 1;
  endtask

  task automatic push_store(input logic [5:0] tag, input logic [31:0] addr, input logic [31:0] data);
    bus.st_ready = 1; bus.st_tag = tag; bus.st_addr = addr; bus.st_data = data;
    cycle();
    bus.st_ready = 0;
  endtask

  task automatic commit_tag(input logic [5:0] tag, input bit flush);
    bus.commit_valid = 1; bus.commit_tag = tag; bus.flush = flush;
    cycle();
    bus.commit_valid = 0; bus.flush = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    idle_inputs();
    reset = 0;

    // Held store waits for commit, then writes one cycle later.
    do_reset();
    push_store(6'd5, 32'h100, 32'hAA);
    repeat (20) cycle();
    commit_tag(6'd5, 0);
    cycle();
    check("t1_we", bus.mem_we, 1);
    check("t1_addr", bus.mem_addr, 32'h100);
    check("t1_data", bus.mem_wdata, 32'hAA);
    bus.mem_ack = 1;
    cycle();
    bus.mem_ack = 0;
    check("t1_empty", bus.empty, 1);

    // Fill, overflow, back-to-back drain.
    do_reset();
    for (int k = 1; k <= 9; k++) push_store(6'(k), 32'h400 + 32'(4 * k), 32'(k));
    check("t2_full", bus.full, 1);
    check("t2_overflow", bus.overflow, 1);
    check("t2_count", bus.count, 8);
    base = writes_seen;
    bus.mem_ack = 1;
    for (int k = 1; k <= 8; k++) commit_tag(6'(k), 0);
    repeat (6) cycle();
    bus.mem_ack = 0;
    check("t2_writes", writes_seen - base, 8);
    check("t2_count_end", bus.count, 0);

    // Commit racing a flush survives; the younger store is discarded.
    do_reset();
    push_store(6'd1, 32'h500, 32'h1);
    push_store(6'd2, 32'h504, 32'h2);
    push_store(6'd3, 32'h508, 32'h3);
    commit_tag(6'd1, 0);
    commit_tag(6'd2, 1);
    base = writes_seen;
    bus.mem_ack = 1;
    repeat (6) cycle();
    bus.mem_ack = 0;
    check("t3_writes", writes_seen - base, 2);
    check("t3_count", bus.count, 0);

    // Asynchronous reset in the middle of an unacknowledged write.
    do_reset();
    for (int k = 1; k <= 9; k++) push_store(6'(k), 32'h600 + 32'(4 * k), 32'(k));
    commit_tag(6'd1, 0);
    cycle();
    check("t4_we_before", bus.mem_we, 1);
    #2;
    reset = 0;
    #1;
    check("t4_we", bus.mem_we, 0);
    check("t4_count", bus.count, 0);
    check("t4_overflow", bus.overflow, 0);

    // Load probes.
    do_reset();
    push_store(6'd1, 32'h200, 32'h11);
    push_store(6'd2, 32'h200, 32'h22);
    bus.ld_check = 1; bus.ld_addr = 32'h200;
    #1;
`ifdef STORE_FWD_EN
    check("t5_hit", bus.ld_hit, 1);
    check("t5_data", bus.ld_data, 32'h22);
    check("t5_stall", bus.ld_stall, 0);
`else
    check("t5_stall", bus.ld_stall, 1);
    check("t5_hit", bus.ld_hit, 0);
`endif
    cycle();
    bus.ld_addr = 32'h202;
    #1;
    check("t6_stall", bus.ld_stall, 1);
    check("t6_hit", bus.ld_hit, 0);
    cycle();
    bus.ld_addr = 32'h300;
    #1;
    check("t6b_stall", bus.ld_stall, 0);
    check("t6b_hit", bus.ld_hit, 0);
    cycle();
    idle_inputs();

    // Random traffic against the model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      idle_inputs();
      if ($urandom_range(0, 99) < 45) begin
        bus.st_ready = 1; bus.st_tag = next_tag;
        bus.st_addr = 32'h200 + 32'($urandom_range(0, 31));
        bus.st_data = $urandom;
        next_tag = (next_tag == 6'd63) ? 6'd1 : next_tag + 6'd1;
      end
      if ($urandom_range(0, 99) < 40) begin
        bus.commit_valid = 1;
        bus.commit_tag = 6'($urandom_range(0, 63));
        for (int i = 0; i < model_q.size(); i++) begin
          if (!model_q[i].committed) begin bus.commit_tag = model_q[i].tag; break; end
        end
        if ($urandom_range(0, 19) == 0) bus.commit_tag = 6'd0;
      end
      bus.flush    = ($urandom_range(0, 99) < 3);
      bus.mem_ack  = ($urandom_range(0, 99) < 60);
      bus.ld_check = ($urandom_range(0, 1) == 1);
      bus.ld_addr  = ($urandom_range(0, 3) == 0) ? $urandom : 32'h200 + 32'($urandom_range(0, 31));
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end
endmodule
